// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - program counter and fetch sequencer ahead of the instruction ROM
module instr_fetch #(
    parameter int PC_W  = 8,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             ResetN,
    input  logic             Start,
    input  logic [PC_W-1:0]  StartAddr,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             JumpEn,
    input  logic [PC_W-1:0]  JumpTarget,
    input  logic             BranchEn,
    input  logic [PC_W-1:0]  BranchOffset,
    output logic [PC_W-1:0]  InstrAddress,
    output logic             Running,
    output logic             Done,
    output logic [CNT_W-1:0] InstrCount
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic             running_q;
    logic             done_q;
    logic [PC_W-1:0]  pc_q;
    logic [PC_W-1:0]  pc_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic [PC_W-1:0]  pc_seq;
    logic [PC_W-1:0]  pc_branch;
    logic [CNT_W-1:0] cnt_inc;

    // Both adders truncate to PC_W bits, so wrap-around and negative offsets fall out naturally.
    assign pc_seq    = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    assign pc_branch = pc_q + BranchOffset;
    // Retired count sticks at all-ones instead of wrapping.
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

    // Next-PC and retired-count selection; halt beats stall, stall beats jump, jump beats branch.
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    pc_d  = StartAddr;
                    cnt_d = '0;
                end
            end
            RUN: begin
                if (Halt) begin
                    cnt_d = cnt_inc;
                end else if (Stall) begin
                    cnt_d = cnt_q;
                end else if (JumpEn) begin
                    pc_d  = JumpTarget;
                    cnt_d = cnt_inc;
                end else if (BranchEn) begin
                    pc_d  = pc_branch;
                    cnt_d = cnt_inc;
                end else begin
                    pc_d  = pc_seq;
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                pc_d  = pc_q;
                cnt_d = cnt_q;
            end
        endcase
    end

    // Run-state FSM with registered Running/Done flags, plus the PC and count registers.
    always_ff @(posedge CLK or negedge ResetN) begin
        if (!ResetN) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            pc_q      <= '0;
            cnt_q     <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            case (state_q)
                IDLE, DONE: begin
                    if (Start) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                RUN: begin
                    if (Halt) begin
                        state_q   <= DONE;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign InstrAddress = pc_q;
    assign InstrCount   = cnt_q;
    assign Running      = running_q;
    assign Done         = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch, with a 4-bit-counter twin for saturation
`timescale 1ns/1ns
module tb_instr_fetch;

    logic       CLK = 1'b0;
    logic       ResetN = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] StartAddr = 8'h00;
    logic       Halt = 1'b0;
    logic       Stall = 1'b0;
    logic       JumpEn = 1'b0;
    logic [7:0] JumpTarget = 8'h00;
    logic       BranchEn = 1'b0;
    logic [7:0] BranchOffset = 8'h00;

    logic [7:0]  addr_a;
    logic        run_a;
    logic        done_a;
    logic [15:0] cnt_a;
    logic [7:0]  addr_b;
    logic        run_b;
    logic        done_b;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    // Observed/expected layout: {addr, cnt16, run, done, addr4, cnt4, run4, done4}
    logic [39:0] exp_q[$];
    logic [39:0] e;
    logic [39:0] obs;

    instr_fetch #(.PC_W(8), .CNT_W(16)) dut (
        .CLK(CLK), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
        .Halt(Halt), .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
        .BranchEn(BranchEn), .BranchOffset(BranchOffset),
        .InstrAddress(addr_a), .Running(run_a), .Done(done_a), .InstrCount(cnt_a)
    );

    instr_fetch #(.PC_W(8), .CNT_W(4)) dut4 (
        .CLK(CLK), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
        .Halt(Halt), .Stall(Stall), .JumpEn(JumpEn), .JumpTarget(JumpTarget),
        .BranchEn(BranchEn), .BranchOffset(BranchOffset),
        .InstrAddress(addr_b), .Running(run_b), .Done(done_b), .InstrCount(cnt_b)
    );

    always #10 CLK = ~CLK;

    assign obs = {addr_a, cnt_a, run_a, done_a, addr_b, cnt_b, run_b, done_b};

    function automatic logic [39:0] pack(input logic [7:0] pc, input logic [15:0] cnt,
                                         input logic run, input logic dn);
        logic [3:0] c4;
        c4 = (cnt > 16'd15) ? 4'hF : cnt[3:0];
        return {pc, cnt, run, dn, pc, c4, run, dn};
    endfunction

    task automatic drive(input logic st, input logic [7:0] sa, input logic h, input logic s,
                         input logic j, input logic [7:0] jt, input logic b, input logic [7:0] bo);
        @(negedge CLK);
        Start = st; StartAddr = sa; Halt = h; Stall = s;
        JumpEn = j; JumpTarget = jt; BranchEn = b; BranchOffset = bo;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        #3;
        exp_q.push_back(pack(8'h00, 16'd0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_state got %h want %h", obs, e);
        end
        @(negedge CLK);
        ResetN = 1'b1;
    endtask

    task automatic test_launch();
        drive(1'b1, 8'h10, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h10, 16'd0, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL launch_first got %h want %h", obs, e);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
            exp_q.push_back(pack(8'h10 + 8'(i), 16'(i), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL launch_seq%0d got %h want %h", i, obs, e);
            end
        end
        // Halt at 0x14 so the next test can restart from DONE.
        drive(1'b0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h14, 16'd5, 1'b0, 1'b1));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL launch_halt got %h want %h", obs, e);
        end
    endtask

    task automatic test_wrap_branch();
        drive(1'b1, 8'hFE, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'hFE, 16'd0, 1'b1, 1'b0));
        tick();
        drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'hFF, 16'd1, 1'b1, 1'b0));
        tick();
        // Sample the first two before queuing more, keeping queue order with sampling order.
        e = exp_q.pop_front();
        checks++;
        if (e[39:32] !== 8'hFE) begin
            errors++;
            $display("FAIL wrap_order got %h want FE", e[39:32]);
        end
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL wrap_ff got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h00, 16'd2, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL wrap_00 got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 1, 8'hFC);
        exp_q.push_back(pack(8'hFC, 16'd3, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL branch_neg got %h want %h", obs, e);
        end
        // Start while running must be ignored: plain sequential step.
        drive(1'b1, 8'h55, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'hFD, 16'd4, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL start_in_run got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 0, 1, 8'h20, 0, 8'h00);
        exp_q.push_back(pack(8'h20, 16'd5, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL jump_20 got %h want %h", obs, e);
        end
    endtask

    task automatic test_priority();
        drive(1'b0, 8'h00, 0, 0, 1, 8'h80, 1, 8'h10);
        exp_q.push_back(pack(8'h80, 16'd6, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL jump_over_branch got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 1, 1, 8'h40, 0, 8'h00);
        exp_q.push_back(pack(8'h80, 16'd6, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL stall_over_jump got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h7F);
        exp_q.push_back(pack(8'hFF, 16'd7, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL branch_pos got %h want %h", obs, e);
        end
        drive(1'b0, 8'h00, 0, 0, 1, 8'h33, 0, 8'h00);
        exp_q.push_back(pack(8'h33, 16'd8, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL jump_33 got %h want %h", obs, e);
        end
    endtask

    task automatic test_halt();
        drive(1'b0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h33, 16'd9, 1'b0, 1'b1));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL halt_done got %h want %h", obs, e);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 8'h00, i == 0, i == 1, i == 2, 8'h99, i == 3, 8'h05);
            exp_q.push_back(pack(8'h33, 16'd9, 1'b0, 1'b1));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL done_hold%0d got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_restart_reset();
        drive(1'b1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h00, 16'd0, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL restart got %h want %h", obs, e);
        end
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
            exp_q.push_back(pack(8'(i), 16'(i), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL restart_seq%0d got %h want %h", i, obs, e);
            end
        end
        // Asynchronous reset pulse between edges, at PC=0x05.
        #3;
        ResetN = 1'b0;
        #1;
        exp_q.push_back(pack(8'h00, 16'd0, 1'b0, 1'b0));
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL async_reset got %h want %h", obs, e);
        end
        #1;
        ResetN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 0, 0, i == 1, 8'h44, i == 2, 8'h02);
            exp_q.push_back(pack(8'h00, 16'd0, 1'b0, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL idle_after_reset%0d got %h want %h", i, obs, e);
            end
        end
    endtask

    task automatic test_saturation();
        drive(1'b1, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
        exp_q.push_back(pack(8'h00, 16'd0, 1'b1, 1'b0));
        tick();
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL sat_start got %h want %h", obs, e);
        end
        for (int i = 1; i <= 24; i++) begin
            drive(1'b0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00);
            exp_q.push_back(pack(8'(i), 16'(i), 1'b1, 1'b0));
            tick();
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_cycle%0d got %h want %h", i, obs, e);
            end
        end
        checks++;
        if (cnt_b !== 4'hF) begin
            errors++;
            $display("FAIL sat_final got %h want f", cnt_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t want finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_launch();
        test_wrap_branch();
        test_priority();
        test_halt();
        test_restart_reset();
        test_saturation();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
